// File: rtl/display_scan_driver.sv
// Multiplexed 4-digit 7-segment scanner: per-frame snapshot, blanking gap between digits.
// Optional per-digit blinking when DISPLAY_BLINK_EN is defined (adds blink_mask_i, BLINK_FRAMES).

module display_scan_lane (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       load_i,
  input  logic [6:0] seg_i,
  output logic [6:0] shadow_o
);
  logic [6:0] shadow_d, shadow_q;

  always_comb begin
    shadow_d = shadow_q;
    if (load_i) shadow_d = seg_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) shadow_q <= '0;
    else          shadow_q <= shadow_d;
  end

  assign shadow_o = shadow_q;
endmodule

module display_scan_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1
`ifdef DISPLAY_BLINK_EN
  , parameter int BLINK_FRAMES = 50
`endif
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic [6:0] digit1_seg_i,
  input  logic [6:0] digit2_seg_i,
  input  logic [6:0] digit3_seg_i,
  input  logic [6:0] digit4_seg_i,
`ifdef DISPLAY_BLINK_EN
  input  logic [3:0] blink_mask_i,
`endif
  output logic       segment_a_o,
  output logic       segment_b_o,
  output logic       segment_c_o,
  output logic       segment_d_o,
  output logic       segment_e_o,
  output logic       segment_f_o,
  output logic       segment_g_o,
  output logic       digit1_o,
  output logic       digit2_o,
  output logic       digit3_o,
  output logic       digit4_o,
  output logic       frame_start_o
);
  localparam int NUM_DIGITS = 4;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [6:0]    SEG_OFF   = {7{SEG_ACTIVE_LOW}};

  logic [CW-1:0] slot_cnt_d, slot_cnt_q;
  logic [1:0]    idx_d, idx_q;
  logic          load_pending_d, load_pending_q;
  logic          frame_start_d, frame_start_q;
  logic [3:0]    digit_d, digit_q;
  logic [6:0]    seg_d, seg_q;
  logic          slot_last, load, in_blank, blanked;

  logic [NUM_DIGITS-1:0][6:0] seg_in, shadow;
  assign seg_in = {digit4_seg_i, digit3_seg_i, digit2_seg_i, digit1_seg_i};

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
    display_scan_lane u_lane (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .load_i   (load),
      .seg_i    (seg_in[k]),
      .shadow_o (shadow[k])
    );
  end

  if (BLANK_CYCLES == 0) begin : g_noblank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (slot_cnt_q < BLANK_END);
  end

  // Counters and snapshot control
  always_comb begin
    slot_last      = (slot_cnt_q == SLOT_LAST);
    load           = enable_i && (load_pending_q || (slot_last && idx_q == 2'd3));
    slot_cnt_d     = slot_cnt_q;
    idx_d          = idx_q;
    load_pending_d = load_pending_q;
    if (enable_i) begin
      slot_cnt_d = slot_last ? '0 : slot_cnt_q + 1'b1;
      if (slot_last) idx_d = idx_q + 2'd1;
    end
    if (load) load_pending_d = 1'b0;
    frame_start_d = load;
  end

`ifdef DISPLAY_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] FC_TOP = FW'(BLINK_FRAMES);
  logic [FW-1:0] frame_cnt_d, frame_cnt_q;
  logic          blink_phase_d, blink_phase_q;

  // The power-on snapshot opens frame 1, so the first flip lands at the start of frame BLINK_FRAMES+1.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (load) begin
      if (frame_cnt_q == FC_TOP) begin
        frame_cnt_d   = FW'(1);
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blanked = blink_phase_q && blink_mask_i[idx_q];
`else
  assign blanked = 1'b0;
`endif

  // Output decode; XOR with SEG_OFF applies the segment polarity
  always_comb begin
    digit_d = '1;
    seg_d   = SEG_OFF;
    if (enable_i && !in_blank) begin
      if (!blanked) digit_d[idx_q] = 1'b0;
      seg_d = shadow[idx_q] ^ SEG_OFF;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot_cnt_q     <= '0;
      idx_q          <= '0;
      load_pending_q <= 1'b1;
      frame_start_q  <= 1'b0;
      digit_q        <= '1;
      seg_q          <= SEG_OFF;
    end else begin
      slot_cnt_q     <= slot_cnt_d;
      idx_q          <= idx_d;
      load_pending_q <= load_pending_d;
      frame_start_q  <= frame_start_d;
      digit_q        <= digit_d;
      seg_q          <= seg_d;
    end
  end

  assign segment_a_o   = seg_q[0];
  assign segment_b_o   = seg_q[1];
  assign segment_c_o   = seg_q[2];
  assign segment_d_o   = seg_q[3];
  assign segment_e_o   = seg_q[4];
  assign segment_f_o   = seg_q[5];
  assign segment_g_o   = seg_q[6];
  assign digit1_o      = digit_q[0];
  assign digit2_o      = digit_q[1];
  assign digit3_o      = digit_q[2];
  assign digit4_o      = digit_q[3];
  assign frame_start_o = frame_start_q;
endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver: stimulus pushes per-cycle expectations, monitor pops and compares.
module tb_display_scan_driver;
  localparam int SD = 8;
  localparam int BL = 2;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic enable_i = 1'b0;
  logic [6:0] d1, d2, d3, d4;
  logic sa, sb, sc, sdd, se, sf, sg;
  logic dg1, dg2, dg3, dg4, fs_o;
`ifdef DISPLAY_BLINK_EN
  logic [3:0] blink_mask = 4'b0001;
`endif

  display_scan_driver #(
    .SCAN_DIV(SD), .BLANK_CYCLES(BL), .SEG_ACTIVE_LOW(1'b1)
`ifdef DISPLAY_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i),
    .digit1_seg_i(d1), .digit2_seg_i(d2), .digit3_seg_i(d3), .digit4_seg_i(d4),
`ifdef DISPLAY_BLINK_EN
    .blink_mask_i(blink_mask),
`endif
    .segment_a_o(sa), .segment_b_o(sb), .segment_c_o(sc), .segment_d_o(sdd),
    .segment_e_o(se), .segment_f_o(sf), .segment_g_o(sg),
    .digit1_o(dg1), .digit2_o(dg2), .digit3_o(dg3), .digit4_o(dg4),
    .frame_start_o(fs_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;
  logic [6:0] exp_sh [4];
  int fno;

  wire [3:0] dig_o = {dg4, dg3, dg2, dg1};
  wire [6:0] seg_o = {sg, sf, se, sdd, sc, sb, sa};

  task automatic compare(input string name, input exp_t e);
    checks++;
    if (dig_o !== e.dig || seg_o !== e.seg || fs_o !== e.fs) begin
      errors++;
      $display("FAIL %s t=%0t got dig=%b seg=%h fs=%b want dig=%b seg=%h fs=%b",
               name, $time, dig_o, seg_o, fs_o, e.dig, e.seg, e.fs);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        compare("scan", e);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the following edge.
  task automatic step(input bit en, input bit rstn, input logic [3:0] dig,
                      input logic [6:0] seg, input bit fs);
    @(negedge clk_i);
    enable_i = en;
    rst_n_i  = rstn;
    sb_q.push_back(exp_t'{dig, seg, fs});
  endtask

  function automatic bit blink_on(input int k);
`ifdef DISPLAY_BLINK_EN
    return (k == 0) && ((((fno - 1) / 2) % 2) == 1);
`else
    return (k < 0);
`endif
  endfunction

  task automatic run_slot(input int k, input int s0, input int s1, input bit first);
    bit fs;
    logic [3:0] dsel;
    for (int s = s0; s <= s1; s++) begin
      fs = (first && k == 0 && s == 0) || (k == 3 && s == SD - 1);
      dsel = blink_on(k) ? 4'hF : (4'hF ^ (4'h1 << k));
      if (s < BL) step(1'b1, 1'b1, 4'hF, 7'h7F, fs);
      else        step(1'b1, 1'b1, dsel, ~exp_sh[k], fs);
    end
  endtask

  task automatic run_frame(input bit first);
    for (int k = 0; k < 4; k++) run_slot(k, 0, SD - 1, first && k == 0);
    fno++;
  endtask

  initial begin : stim
    d1 = 7'h06; d2 = 7'h5B; d3 = 7'h4F; d4 = 7'h66;
    exp_sh[0] = 7'h06; exp_sh[1] = 7'h5B; exp_sh[2] = 7'h4F; exp_sh[3] = 7'h66;
    fno = 1;
    repeat (3) step(1'b1, 1'b0, 4'hF, 7'h7F, 1'b0);
    run_frame(1'b1);

    // digit2 input changes mid-frame; the snapshot keeps 5B until the frame boundary
    run_slot(0, 0, 3, 1'b0);
    d2 = 7'h3F;
    run_slot(0, 4, SD - 1, 1'b0);
    for (int k = 1; k < 4; k++) run_slot(k, 0, SD - 1, 1'b0);
    fno++;
    exp_sh[1] = 7'h3F;

    // enable dropped for 10 cycles in the middle of digit3
    run_slot(0, 0, SD - 1, 1'b0);
    run_slot(1, 0, SD - 1, 1'b0);
    run_slot(2, 0, 4, 1'b0);
    repeat (10) step(1'b0, 1'b1, 4'hF, 7'h7F, 1'b0);
    run_slot(2, 5, SD - 1, 1'b0);
    run_slot(3, 0, SD - 1, 1'b0);
    fno++;

    // asynchronous reset between edges during digit2 drive
    run_slot(0, 0, SD - 1, 1'b0);
    run_slot(1, 0, 4, 1'b0);
    @(posedge clk_i);
    #3 rst_n_i = 1'b0;
    #1 compare("async_reset", exp_t'{4'hF, 7'h7F, 1'b0});
    d1 = 7'h6D; d2 = 7'h7D; d3 = 7'h07; d4 = 7'h7F;
    repeat (2) step(1'b1, 1'b0, 4'hF, 7'h7F, 1'b0);
    exp_sh[0] = 7'h6D; exp_sh[1] = 7'h7D; exp_sh[2] = 7'h07; exp_sh[3] = 7'h7F;
    fno = 1;
    run_frame(1'b1);
    repeat (7) run_frame(1'b0);

    repeat (3) step(1'b0, 1'b1, 4'hF, 7'h7F, 1'b0);
    repeat (3) @(negedge clk_i);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d entries left want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Sequential driver for the board's 4-digit multiplexed 7-segment display. It consumes the segment patterns produced by the tank-level and irrigation-condition decoders and drives the physical segment_a..g and digit1..4 lines.
- Scans one digit at a time at a fixed rate, with a blanking gap between digits to suppress ghosting.
- Snapshots all four input patterns once per frame so a digit never shows a half-updated value.
- Replaces the static digit1-only selection in the top level.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 500, cycles at the start of each slot with all digits off; 0 <= BLANK_CYCLES < SCAN_DIV.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (0 = lit); 0 = 1 is lit.

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  asynchronous reset, active-low
- enable_i  input  1  1 = scanning; 0 = display dark and counters frozen
- digit1_seg_i  input  7  pattern for digit1; bit0 = a … bit6 = g; 1 = lit
- digit2_seg_i  input  7  pattern for digit2, same encoding
- digit3_seg_i  input  7  pattern for digit3, same encoding
- digit4_seg_i  input  7  pattern for digit4, same encoding
- segment_a_o … segment_g_o  output  1 each  registered segment drive, polarity per SEG_ACTIVE_LOW
- digit1_o … digit4_o  output  1 each  registered digit select, active-low (0 = digit on)
- frame_start_o  output  1  one-cycle pulse after each snapshot load

Behaviour:
- Interface decision: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values:
  - digit1_o..digit4_o = 1.
  - Segments at the inactive level: 1 if SEG_ACTIVE_LOW, else 0.
  - frame_start_o = 0.
  - slot_cnt = 0, idx = 0.
  - Shadow patterns = 7'h00.
  - load_pending = 1.
- Counters (update only on edges where enable_i = 1):
  - slot_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On that wrap, idx increments 0→1→2→3→0.
- Snapshot: all four shadow registers load from digitN_seg_i on any enabled edge where either:
  - load_pending = 1 (the first enabled edge after reset), or
  - idx = 3 and slot_cnt = SCAN_DIV-1 (end of frame).
  - load_pending clears on the first snapshot.
  - frame_start_o = 1 for exactly the cycle following each load.
- Slot phases, decoded from the current idx and slot_cnt:
  - BLANK: slot_cnt < BLANK_CYCLES.
  - DRIVE: otherwise.
- Registered outputs; these are the values latched at each edge, so they appear one cycle later:
  - digit(k)_o = 0 only when enable_i = 1, idx = k-1 and the phase is DRIVE. All other digits = 1.
  - Segments show shadow[idx] in DRIVE (inverted if SEG_ACTIVE_LOW). In BLANK they are at the inactive level.
- enable_i = 0:
  - Counters and shadows hold.
  - Next cycle: all digits = 1, segments inactive, frame_start_o = 0.
  - On re-enable, scanning resumes from the held idx/slot_cnt. There is no new snapshot until the frame boundary or a pending load.
- Input changes mid-frame are invisible until the next snapshot.
- Reset asserted mid-scan forces all reset values immediately (asynchronously), including load_pending = 1.
- Frame period = 4*SCAN_DIV enabled cycles. Each digit's on-time = SCAN_DIV - BLANK_CYCLES.
- With BLANK_CYCLES = 0, consecutive digit slots abut with no dark gap.

Optional Feature:
- Macro: DISPLAY_BLINK_EN.
- Defined:
  - Adds input blink_mask_i [3:0] (bit k-1 = digit k) and parameter BLINK_FRAMES (default 50).
  - A frame counter increments on each snapshot load. blink_phase toggles every BLINK_FRAMES loads.
  - While blink_phase = 1, any digit whose mask bit is set stays at digit(k)_o = 1 for its whole slot.
  - Reset values: blink_phase = 0, frame counter = 0.
- Undefined: no blink_mask_i port and no frame counter; behaviour as above.

Test Plan:
- Reset check: SCAN_DIV=8, BLANK_CYCLES=2, rst_n_i held low → digits 4'b1111, segments all 1, frame_start_o=0. Release with enable_i=1 → frame_start_o pulses on cycle 2.
- Scan order, same parameters, inputs 7'h06/7'h5B/7'h4F/7'h66 → each slot: 2 dark cycles, then 6 cycles of that digit low with the inverted pattern. Order digit1→4, repeating every 32 cycles.
- Tearing: change digit2_seg_i from 7'h5B to 7'h3F during digit1's slot → digit2 still shows 7'h5B this frame and 7'h3F from the next frame. frame_start_o pulses once per 32 cycles.
- Enable hold: drop enable_i for 10 cycles mid-digit3 → all digits dark, no frame_start_o. After re-enable, digit3 finishes its remaining cycles.
- Async reset mid-scan: assert rst_n_i between clock edges during digit2 DRIVE → outputs return to reset values without waiting for a clock edge. After release, a fresh snapshot is taken.
- DISPLAY_BLINK_EN, BLINK_FRAMES=2, blink_mask_i=4'b0001 → digit1 dark in frames 3–4 and 7–8. Digits 2–4 are unaffected.
